// File: rtl/regfile_pkg.sv
// Shared types and sizes for the register-file write scheduler.
package regfile_pkg;
  localparam int N        = 32;
  localparam int ADD      = $clog2(N);
  localparam int ZERO_REG = 0;
  localparam int NREG     = N;

  typedef enum logic { CLEAR, RUN } state_e;
  typedef enum logic { PORT_A, PORT_B } port_e;

  typedef struct packed {
    logic [ADD-1:0] addr;
    logic [N-1:0]   data;
  } wr_req_t;
endpackage

// File: rtl/regfile_write_scheduler_wb_slot.sv
// One-entry holding register for a pending register-file write.
import regfile_pkg::*;

module wb_slot (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    load,
  input  logic    drain,
  input  wr_req_t req_in,
  output logic    full,
  output wr_req_t req
);
  // load wins over drain so a drained slot can be refilled on the same edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full <= 1'b0;
      req  <= '0;
    end else if (load) begin
      full <= 1'b1;
      req  <= req_in;
    end else if (drain) begin
      full <= 1'b0;
    end
  end
endmodule

// File: rtl/regfile_write_scheduler.sv
// Single write port of the MIPS register file: zero-fill after reset, then
// round-robin arbitration between the writeback (A) and loader (B) slots.
import regfile_pkg::*;

module regfile_write_scheduler (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           a_valid,
  output logic           a_ready,
  input  logic [ADD-1:0] a_addr,
  input  logic [N-1:0]   a_data,
  input  logic           b_valid,
  output logic           b_ready,
  input  logic [ADD-1:0] b_addr,
  input  logic [N-1:0]   b_data,
  output logic           rf_wr,
  output logic [ADD-1:0] rf_addr,
  output logic [N-1:0]   rf_data,
  output logic           init_busy
);
  localparam int NPORT = 2;

  state_e         state, state_nx;
  logic [ADD-1:0] clr_cnt;
  port_e          rr_ptr;

  logic [NPORT-1:0] vld, rdy, load, grant, full;
  wr_req_t          in_req   [NPORT];
  wr_req_t          slot_req [NPORT];
  wr_req_t          sel;

  // index 0 is port A, index 1 is port B
  assign vld       = {b_valid, a_valid};
  assign in_req[0] = '{addr: a_addr, data: a_data};
  assign in_req[1] = '{addr: b_addr, data: b_data};
  assign a_ready   = rdy[0];
  assign b_ready   = rdy[1];
  assign load      = vld & rdy;

  for (genvar i = 0; i < NPORT; i++) begin : g_slot
    wb_slot u_slot (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (load[i]),
      .drain  (grant[i]),
      .req_in (in_req[i]),
      .full   (full[i]),
      .req    (slot_req[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= CLEAR;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (state == CLEAR && clr_cnt == ADD'(N-1)) state_nx = RUN;
  end

  // grant depends only on slot occupancy and rr_ptr, never on valid
  always_comb begin
    grant = '0;
    if (state == RUN) begin
      if (&full) grant = (rr_ptr == PORT_A) ? 2'b01 : 2'b10;
      else       grant = full;
    end
    rdy = (state == RUN) ? (~full | grant) : '0;
    sel = grant[1] ? slot_req[1] : slot_req[0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_wr     <= 1'b0;
      rf_addr   <= '0;
      rf_data   <= '0;
      init_busy <= 1'b1;
      clr_cnt   <= ADD'(1);
      rr_ptr    <= PORT_A;
    end else if (state == CLEAR) begin
      rf_wr   <= 1'b1;
      rf_addr <= clr_cnt;
      rf_data <= '0;
      if (clr_cnt == ADD'(N-1)) init_busy <= 1'b0;
      else                      clr_cnt   <= clr_cnt + ADD'(1);
    end else if (|grant) begin
      // a write to $zero is consumed as a grant but never reaches the file
      rf_wr   <= (sel.addr != ADD'(ZERO_REG));
      rf_addr <= sel.addr;
      rf_data <= sel.data;
      rr_ptr  <= grant[0] ? PORT_B : PORT_A;
    end else begin
      rf_wr <= 1'b0;
    end
  end
endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Bench for regfile_write_scheduler: directed table, corner sequences and a
// randomized run against a queue-based transaction model.
module tb_regfile_write_scheduler;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_valid, b_valid;
  logic        a_ready, b_ready;
  logic [4:0]  a_addr, b_addr;
  logic [31:0] a_data, b_data;
  logic        rf_wr;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic        init_busy;

  regfile_write_scheduler dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .rf_wr(rf_wr), .rf_addr(rf_addr), .rf_data(rf_data), .init_busy(init_busy)
  );

  always #5 clk = ~clk;

  // register file fed by the DUT write port
  logic [31:0] bench_rf [32];
  initial begin
    bench_rf[0] = 32'h0;
    for (int i = 1; i < 32; i++) bench_rf[i] = 32'hFFFF_FFFF;
  end
  always @(posedge clk) if (rf_wr) bench_rf[rf_addr] <= rf_data;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  typedef struct { logic [4:0] addr; logic [31:0] data; } ent_t;
  ent_t        qa[$], qb[$];
  bit          known = 0;
  bit          run;
  int          clr;
  int          prefer;          // 0 = A next on contention, 1 = B
  logic        exp_wr, exp_busy;
  logic [4:0]  exp_addr;
  logic [31:0] exp_data;
  logic [31:0] model_rf [32];
  initial begin
    model_rf[0] = 32'h0;
    for (int i = 1; i < 32; i++) model_rf[i] = 32'hFFFF_FFFF;
  end

  task automatic tick();
    int g;
    bit ar, br, av, bv;
    ent_t ea, eb, e;
    g = -1;
    if (run) begin
      if (qa.size() > 0 && qb.size() > 0) g = prefer;
      else if (qa.size() > 0)             g = 0;
      else if (qb.size() > 0)             g = 1;
    end
    ar = run && (qa.size() == 0 || g == 0);
    br = run && (qb.size() == 0 || g == 1);
    if (known && rst_n) begin
      check("a_ready", a_ready, ar);
      check("b_ready", b_ready, br);
    end
    av = a_valid; bv = b_valid;
    ea = '{a_addr, a_data}; eb = '{b_addr, b_data};
    @(posedge clk);
    if (!rst_n) begin
      known = 1; run = 0; clr = 1; prefer = 0;
      qa.delete(); qb.delete();
      exp_wr = 0; exp_addr = 0; exp_data = 0; exp_busy = 1;
    end else if (known && !run) begin
      exp_wr = 1; exp_addr = 5'(clr); exp_data = 0;
      model_rf[clr] = 0;
      if (clr == 31) begin run = 1; exp_busy = 0; end
      clr++;
    end else if (known) begin
      exp_wr = 0;
      if (g >= 0) begin
        e = (g == 0) ? qa.pop_front() : qb.pop_front();
        exp_addr = e.addr; exp_data = e.data;
        exp_wr = (e.addr != 0);
        if (exp_wr) model_rf[e.addr] = e.data;
        prefer = 1 - g;
      end
      if (av && ar) qa.push_back(ea);
      if (bv && br) qb.push_back(eb);
    end
    #1;
    if (known) begin
      check("rf_wr", rf_wr, exp_wr);
      check("rf_addr", rf_addr, exp_addr);
      check("rf_data", rf_data, exp_data);
      check("init_busy", init_busy, exp_busy);
    end
  endtask

  task automatic idle();
    a_valid = 0; b_valid = 0; a_addr = 0; b_addr = 0; a_data = 0; b_data = 0;
  endtask

  task automatic compare_rf(input string tag);
    for (int i = 0; i < 32; i++) check(tag, bench_rf[i], model_rf[i]);
  endtask

  task automatic zero_fill_check();
    for (int i = 1; i <= 31; i++) begin
      tick();
      check("zf_wr", rf_wr, 1'b1);
      check("zf_addr", rf_addr, i);
      check("zf_data", rf_data, 0);
      check("zf_busy", init_busy, (i < 31));
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic av; logic [4:0] aa; logic [31:0] ad;
    logic bv; logic [4:0] ba; logic [31:0] bd;
    logic ar; logic br;
    logic wr; logic [4:0] wa; logic [31:0] wd;
  } vec_t;
  vec_t tbl [18];

  initial begin
    tbl[0]  = '{1, 5, 32'hDEADBEEF, 0, 0, 0,        1, 1, 0, 31, 0};
    tbl[1]  = '{0, 0, 0,            0, 0, 0,        1, 1, 1, 5, 32'hDEADBEEF};
    tbl[2]  = '{0, 0, 0,            0, 0, 0,        1, 1, 0, 5, 32'hDEADBEEF};
    tbl[3]  = '{1, 1, 32'h11,       0, 0, 0,        1, 1, 0, 5, 32'hDEADBEEF};
    tbl[4]  = '{1, 2, 32'h22,       0, 0, 0,        1, 1, 1, 1, 32'h11};
    tbl[5]  = '{1, 3, 32'h33,       0, 0, 0,        1, 1, 1, 2, 32'h22};
    tbl[6]  = '{1, 4, 32'h44,       0, 0, 0,        1, 1, 1, 3, 32'h33};
    tbl[7]  = '{0, 0, 0,            0, 0, 0,        1, 1, 1, 4, 32'h44};
    tbl[8]  = '{0, 0, 0,            0, 0, 0,        1, 1, 0, 4, 32'h44};
    tbl[9]  = '{1, 7, 32'h77,       1, 0, 32'h1234, 1, 1, 0, 4, 32'h44};
    tbl[10] = '{0, 0, 0,            0, 0, 0,        0, 1, 0, 0, 32'h1234};
    tbl[11] = '{0, 0, 0,            0, 0, 0,        1, 1, 1, 7, 32'h77};
    tbl[12] = '{1, 8, 32'h88,       1, 8, 32'h99,   1, 1, 0, 7, 32'h77};
    tbl[13] = '{1, 9, 32'hA9,       1, 10, 32'hBA,  0, 1, 1, 8, 32'h99};
    tbl[14] = '{1, 9, 32'hA9,       1, 10, 32'hBA,  1, 0, 1, 8, 32'h88};
    tbl[15] = '{0, 0, 0,            0, 0, 0,        0, 1, 1, 10, 32'hBA};
    tbl[16] = '{0, 0, 0,            0, 0, 0,        1, 1, 1, 9, 32'hA9};
    tbl[17] = '{0, 0, 0,            0, 0, 0,        1, 1, 0, 9, 32'hA9};
  end

  initial begin
    idle();
    rst_n = 0;
    tick(); tick();
    check("rst_wr", rf_wr, 0);
    check("rst_addr", rf_addr, 0);
    check("rst_data", rf_data, 0);
    check("rst_busy", init_busy, 1);
    check("rst_a_ready", a_ready, 0);
    check("rst_b_ready", b_ready, 0);

    rst_n = 1;
    zero_fill_check();
    tick();
    compare_rf("rf_after_fill");

    for (int i = 0; i < 18; i++) begin
      a_valid = tbl[i].av; a_addr = tbl[i].aa; a_data = tbl[i].ad;
      b_valid = tbl[i].bv; b_addr = tbl[i].ba; b_data = tbl[i].bd;
      check($sformatf("tbl%0d_a_ready", i), a_ready, tbl[i].ar);
      check($sformatf("tbl%0d_b_ready", i), b_ready, tbl[i].br);
      tick();
      check($sformatf("tbl%0d_wr", i), rf_wr, tbl[i].wr);
      check($sformatf("tbl%0d_addr", i), rf_addr, tbl[i].wa);
      check($sformatf("tbl%0d_data", i), rf_data, tbl[i].wd);
    end
    idle();
    tick(); tick();
    check("r5", bench_rf[5], 32'hDEADBEEF);
    check("r0", bench_rf[0], 32'h0);
    check("r8_last_wins", bench_rf[8], 32'h88);
    check("r4", bench_rf[4], 32'h44);
    compare_rf("rf_after_table");

    for (int c = 0; c < 1500; c++) begin
      a_valid = ($urandom_range(0, 3) != 0);
      b_valid = ($urandom_range(0, 2) != 0);
      a_addr  = 5'($urandom_range(0, 31));
      b_addr  = 5'($urandom_range(0, 31));
      a_data  = $urandom;
      b_data  = $urandom;
      tick();
    end
    idle();
    tick(); tick(); tick();
    compare_rf("rf_after_random");

    // mid-stream reset with both slots occupied
    a_valid = 1; a_addr = 3; a_data = 32'h333;
    b_valid = 1; b_addr = 6; b_data = 32'h666;
    tick();
    a_addr = 12; a_data = 32'hC0C0; b_addr = 13; b_data = 32'hD0D0;
    tick();
    rst_n = 0;
    tick();
    check("mrst_wr", rf_wr, 0);
    check("mrst_addr", rf_addr, 0);
    check("mrst_data", rf_data, 0);
    check("mrst_busy", init_busy, 1);
    idle();
    rst_n = 1;
    zero_fill_check();
    tick(); tick(); tick();
    compare_rf("rf_after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
